// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter that lends one prescaled down-counter to four delay requesters
// and pulses the owner's done when its delay of N ticks (PRESCALE+1 cycles each) expires.
module delay_timer_arbiter #(
    parameter logic [31:0] PRESCALE = 32'd10000,
    parameter int          CW       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*CW-1:0] delay_in,
    output logic [3:0]      grant,
    output logic [3:0]      done,
    output logic            busy,
    output logic            tick
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   pre_q, pre_d;
    logic [CW-1:0] rem_q, rem_d;

    logic          sel_found;
    logic [1:0]    sel_idx;
    logic [1:0]    cand;
    logic [CW-1:0] sel_delay;
    logic          pre_hit;

    assign pre_hit = (pre_q == PRESCALE);

    // First requester at or after ptr, wrapping mod 4, and the delay it asks for.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = '0;
        sel_delay = '0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (sel_idx == 2'(i)) begin
                sel_delay = delay_in[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    rem_d   = sel_delay;
                    pre_d   = '0;
                    state_d = (sel_delay != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                // A dropped request wins over an expiry landing in the same cycle.
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 2'd1;
                end else if (pre_hit) begin
                    pre_d = '0;
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    pre_d = pre_q + 32'd1;
                end
            end
            DONE: begin
                ptr_d   = idx_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            pre_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs decode from registers only, so reset clears them without a clock edge.
    always_comb begin
        grant = '0;
        done  = '0;
        if (state_q == COUNT) begin
            grant[idx_q] = 1'b1;
        end
        if (state_q == DONE) begin
            done[idx_q] = 1'b1;
        end
        busy = (state_q == COUNT);
        tick = (state_q == COUNT) && pre_hit;
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Self-checking bench for delay_timer_arbiter at PRESCALE=3 (4-cycle tick): directed
// scenarios plus random transactions checked against cycle formulas and a round-robin model.
module tb_delay_timer_arbiter;

    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [4*CW-1:0] delayIn;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            busy;
    logic            tick;

    int checks = 0;
    int errors = 0;
    int expPtr = 0;

    always #5 clk = ~clk;

    delay_timer_arbiter #(
        .PRESCALE(32'd3),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .delay_in(delayIn),
        .grant(grant),
        .done(done),
        .busy(busy),
        .tick(tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [4*CW-1:0] dl);
        req     = r;
        delayIn = dl;
    endtask

    task automatic checkOutput(input string tag, input int cyc, input logic [3:0] eGrant,
                               input logic [3:0] eDone, input logic eBusy, input logic eTick);
        checks++;
        assert ({grant, done, busy, tick} === {eGrant, eDone, eBusy, eTick}) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: got grant=%b done=%b busy=%b tick=%b, want grant=%b done=%b busy=%b tick=%b",
                   tag, cyc, grant, done, busy, tick, eGrant, eDone, eBusy, eTick);
        end
    endtask

    function automatic int pickRR(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One requester alone: COUNT for cycles 1..D*4 (ticks every 4th), done at D*4+1,
    // or, if dropped at cycle abortAt, idle from abortAt+1 with no done.
    task automatic runTxn(input string tag, input int ch, input int d, input int abortAt);
        logic [4*CW-1:0] dl;
        logic [3:0]      oh;
        int              stop;
        oh = 4'b0001 << ch;
        dl = {$urandom, $urandom};
        dl[ch*CW +: CW] = CW'(d);
        applyStimulus(oh, dl);
        if (d == 0) begin
            step();
            checkOutput(tag, 1, 4'b0000, oh, 1'b0, 1'b0);
            req = 4'b0000;
            step();
            checkOutput(tag, 2, 4'b0000, 4'b0000, 1'b0, 1'b0);
        end else begin
            stop = (abortAt != 0) ? abortAt : d * 4;
            for (int c = 1; c <= stop + 1; c++) begin
                step();
                if (c <= stop)
                    checkOutput(tag, c, oh, 4'b0000, 1'b1, (c % 4 == 0));
                else
                    checkOutput(tag, c, 4'b0000, (abortAt == 0) ? oh : 4'b0000, 1'b0, 1'b0);
                if (c == abortAt || c == stop + 1) req = 4'b0000;
            end
            step();
            checkOutput(tag, stop + 2, 4'b0000, 4'b0000, 1'b0, 1'b0);
        end
        expPtr = (ch + 1) % 4;
    endtask

    // Several requesters at once: the model's round-robin winner must be granted, then aborted.
    task automatic arbCheck(input string tag, input logic [3:0] r);
        int         w;
        logic [3:0] oh;
        w  = pickRR(r, expPtr);
        oh = 4'b0001 << w;
        applyStimulus(r, {4{16'd5}});
        step();
        checkOutput(tag, 1, oh, 4'b0000, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        checkOutput(tag, 2, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expPtr = (w + 1) % 4;
    endtask

    // All four request with delay 1; owner k serves in the 6-cycle slot starting at cycle 6k+1.
    task automatic contention();
        int         k;
        int         r;
        logic [3:0] oh;
        applyStimulus(4'b1111, {4{16'd1}});
        for (int c = 1; c <= 24; c++) begin
            step();
            k  = (c - 1) / 6;
            r  = (c - 1) % 6;
            oh = 4'b0001 << k;
            checkOutput("contention", c, (r < 4) ? oh : 4'b0000, (r == 4) ? oh : 4'b0000,
                        (r < 4), (r == 3));
            if (r == 5) req[k] = 1'b0;
        end
        expPtr = 0;
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ch;
        int d;
        int ab;
        rst = 1'b1;
        applyStimulus(4'b0000, '0);
        #12;
        checkOutput("reset", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        contention();
        arbCheck("ptrWrap", 4'b1001);
        runTxn("single", 0, 2, 0);
        runTxn("zeroDelay", 1, 0, 0);
        runTxn("abort", 2, 5, 6);
        arbCheck("afterAbort", 4'b1001);
        arbCheck("afterAbort2", 4'b0001);

        // Reset in the middle of a count must clear the outputs before any clock edge.
        applyStimulus(4'b0001, {48'd0, 16'd2});
        for (int c = 1; c <= 5; c++) begin
            step();
            checkOutput("preReset", c, 4'b0001, 4'b0000, 1'b1, (c % 4 == 0));
        end
        #1 rst = 1'b1;
        #1 checkOutput("rstMid", 5, 4'b0000, 4'b0000, 1'b0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        expPtr = 0;
        runTxn("postReset", 0, 2, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                arbCheck("randArb", 4'($urandom_range(1, 15)));
            end else begin
                ch = $urandom_range(0, 3);
                d  = $urandom_range(0, 4);
                ab = (d > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, d * 4) : 0;
                runTxn("randTxn", ch, d, ab);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
